// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and requester-index helpers.
// Used by the write arbiter and the register file itself.
package regfile_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_REGS    = 2 ** ADDR_W;
  localparam int unsigned DEF_NUM_REQ = 4;

  // Index width for n requesters, kept at least one bit wide.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_IDX_W = idx_width(DEF_NUM_REQ);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bus, issue-stage reservation port and register-file write port 0.
// master = requesters/issue/regfile side, slave = the arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic                      rsv_ready;

  logic                      rf_write_enable;
  logic [ADDR_W-1:0]         rf_write_addr;
  logic [DATA_W-1:0]         rf_write_data;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, rsv_ready, rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, rsv_ready, rf_write_enable, rf_write_addr, rf_write_data
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
// Shared with the read-port scheduler.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic              found;
  int unsigned       idx;
  logic [IDX_W-1:0]  sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin writeback arbiter with a registered write stage feeding regfile write port 0,
// plus a per-register pending-write scoreboard used by issue for RAW/WAW stalls.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  regfile_write_arbiter_if.slave bus,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  err_unreserved_write
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  req_ready;
  logic                xfer;
  logic [IDX_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                err_q, err_d;
  logic                rsv_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    req_ready = (rst || flush) ? '0 : grant;
    xfer      = |(bus.req_valid & req_ready);
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The commit clears its bit before a reservation may set one; same-address overlap
  // is impossible because a pending bit blocks the reservation.
  always_comb begin
    rsv_ok = bus.rsv_valid & ~pend_q[bus.rsv_addr] & ~flush & ~rst;
    pend_d = pend_q;
    err_d  = err_q;
    if (we_q) begin
      if (!pend_q[waddr_q] && !flush) begin
        err_d = 1'b1;
      end
      pend_d[waddr_q] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[bus.rsv_addr] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= xfer;
      pend_q <= pend_d;
      err_q  <= err_d;
      if (xfer) begin
        ptr_q   <= grant_idx;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.req_ready         = req_ready;
  assign bus.rsv_ready         = rsv_ok;
  assign bus.rf_write_enable   = we_q;
  assign bus.rf_write_addr     = waddr_q;
  assign bus.rf_write_data     = wdata_q;
  assign pending_mask          = pend_q;
  assign err_unreserved_write  = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a randomized run
// checked against a queue/array-level model of arbitration, write stage and scoreboard.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned NR = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [NUM_REGS-1:0] pending_mask;
  logic                err;

  regfile_write_arbiter_if #(.NUM_REQ(NR)) bus ();

  regfile_write_arbiter #(.NUM_REQ(NR)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .bus                  (bus.slave),
    .pending_mask         (pending_mask),
    .err_unreserved_write (err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  always @(posedge clk) if (bus.rf_write_enable) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester and issue stimulus.
  bit   [NR-1:0]     v;
  logic [ADDR_W-1:0] a [NR];
  logic [DATA_W-1:0] d [NR];
  bit                rsv_v;
  logic [ADDR_W-1:0] rsv_a;

  // Behavioural model.
  int                m_ptr;
  bit [NUM_REGS-1:0] m_pend;
  bit                m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                m_err;
  int                m_last;

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]                   = v[i];
      bus.req_addr[i*ADDR_W +: ADDR_W]   = a[i];
      bus.req_data[i*DATA_W +: DATA_W]   = d[i];
    end
    bus.rsv_valid = rsv_v;
    bus.rsv_addr  = rsv_a;
  endtask

  task automatic model_reset();
    m_ptr = NR - 1; m_pend = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_err = 0; m_last = -1;
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NR; k++) begin
      int idx = (m_ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int g = model_grant();
    if (flush || g < 0) return '0;
    return NR'(1) << g;
  endfunction

  function automatic bit exp_rsv_ready();
    return rsv_v && !m_pend[rsv_a] && !flush;
  endfunction

  task automatic model_edge();
    int g = model_grant();
    bit ok = !flush && (g >= 0);
    bit [NUM_REGS-1:0] np = m_pend;
    if (m_we) begin
      if (!m_pend[m_waddr] && !flush) m_err = 1;
      np[m_waddr] = 0;
    end
    if (exp_rsv_ready()) np[rsv_a] = 1;
    if (flush) np = '0;
    m_pend = np;
    m_we   = ok;
    m_last = ok ? g : -1;
    if (ok) begin
      m_waddr = a[g];
      m_wdata = d[g];
      m_ptr   = g;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; v = '0; rsv_v = 0; rsv_a = '0;
    for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end
    apply();
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; v = '1; rsv_v = 1; rsv_a = 5'd3;
    for (int i = 0; i < NR; i++) begin a[i] = ADDR_W'(i + 1); d[i] = 32'hA0 + i; end
    apply();
    model_reset();
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== '0) begin n_fail++;
      $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_checks++; if (bus.rsv_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_rsv_ready: got %b want 0", bus.rsv_ready); end
    n_checks++; if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data} !== '0) begin
      n_fail++; $display("FAIL reset_rf_write: got we=%b a=%0d d=%h want all 0",
        bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
    n_checks++; if (pending_mask !== '0 || err !== 1'b0) begin n_fail++;
      $display("FAIL reset_sb: got pend=%h err=%b want 0/0", pending_mask, err); end
    @(negedge clk);
    rst = 0; #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
  endtask

  task automatic test_two_req();
    do_reset();
    v = 4'b0101; a[0] = 5'd3; d[0] = 32'h0000_00A0; a[2] = 5'd12; d[2] = 32'h0000_00C2;
    apply(); #1;
    n_checks++; if (bus.req_ready !== 4'b0001 || bus.rf_write_enable !== 1'b0) begin n_fail++;
      $display("FAIL two_c1: got rdy=%b we=%b want 0001/0", bus.req_ready, bus.rf_write_enable);
    end
    tick(); v[0] = 0; apply(); #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++;
      $display("FAIL two_c2_ready: got %b want 0100", bus.req_ready); end
    n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd3 ||
                    bus.rf_write_data !== 32'h0000_00A0) begin n_fail++;
      $display("FAIL two_c2_write: got we=%b a=%0d d=%h want 1/3/a0",
        bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
    tick(); v[2] = 0; apply(); #1;
    n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd12 ||
                    bus.rf_write_data !== 32'h0000_00C2) begin n_fail++;
      $display("FAIL two_c3_write: got we=%b a=%0d d=%h want 1/12/c2",
        bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data); end
    tick(); #1;
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++;
      $display("FAIL two_c4_idle: got we=%b want 0", bus.rf_write_enable); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    v = '1;
    for (int i = 0; i < NR; i++) begin a[i] = ADDR_W'(16 + i); d[i] = 32'h1000 + i; end
    for (int k = 0; k < 8; k++) begin
      apply(); #1;
      n_checks++; if (bus.req_ready !== (NR'(1) << (k % NR))) begin n_fail++;
        $display("FAIL b2b_grant%0d: got %b want %b", k, bus.req_ready, NR'(1) << (k % NR)); end
      if (k > 0) begin
        n_checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== ADDR_W'(16 + (k - 1) % NR))
        begin n_fail++;
          $display("FAIL b2b_write%0d: got we=%b a=%0d want 1/%0d", k, bus.rf_write_enable,
            bus.rf_write_addr, 16 + (k - 1) % NR); end
      end
      tick();
    end
    v = '0; apply(); #1;
    n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd19) begin n_fail++;
      $display("FAIL b2b_last: got we=%b a=%0d want 1/19", bus.rf_write_enable,
        bus.rf_write_addr); end
    tick(); #1;
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain: got we=%b want 0", bus.rf_write_enable); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_v = 1; rsv_a = 5'd5; apply(); #1;
    n_checks++; if (bus.rsv_ready !== 1'b1) begin n_fail++;
      $display("FAIL sb_rsv_accept: got %b want 1", bus.rsv_ready); end
    tick(); #1;
    n_checks++; if (pending_mask !== 32'h0000_0020) begin n_fail++;
      $display("FAIL sb_pending_set: got %h want 00000020", pending_mask); end
    n_checks++; if (bus.rsv_ready !== 1'b0) begin n_fail++;
      $display("FAIL sb_rsv_stall: got %b want 0", bus.rsv_ready); end
    rsv_v = 0; v[1] = 1; a[1] = 5'd5; d[1] = 32'hDEADBEEF; apply(); #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++;
      $display("FAIL sb_req1_grant: got %b want 0010", bus.req_ready); end
    tick(); v[1] = 0; apply(); #1;
    n_checks++; if (pending_mask !== 32'h0000_0020 || bus.rf_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL sb_staged: got pend=%h we=%b want 00000020/1", pending_mask,
        bus.rf_write_enable); end
    tick(); #1;
    n_checks++; if (pending_mask !== '0 || err !== 1'b0) begin n_fail++;
      $display("FAIL sb_commit: got pend=%h err=%b want 0/0", pending_mask, err); end
    n_checks++; if (rf_mem[5] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL sb_regfile_r5: got %h want deadbeef", rf_mem[5]); end
  endtask

  task automatic test_unreserved();
    do_reset();
    v[3] = 1; a[3] = 5'd7; d[3] = 32'h7777_0007; apply();
    tick(); v[3] = 0; apply(); #1;
    n_checks++; if (bus.rf_write_enable !== 1'b1 || err !== 1'b0) begin n_fail++;
      $display("FAIL unres_pre: got we=%b err=%b want 1/0", bus.rf_write_enable, err); end
    tick(); #1;
    n_checks++; if (err !== 1'b1) begin n_fail++;
      $display("FAIL unres_flag: got %b want 1", err); end
    repeat (3) tick();
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++;
      $display("FAIL unres_sticky: got %b want 1", err); end
    do_reset(); #1;
    n_checks++; if (err !== 1'b0) begin n_fail++;
      $display("FAIL unres_clear: got %b want 0", err); end
  endtask

  task automatic setup_staged();
    do_reset();
    rsv_v = 1; rsv_a = 5'd0; apply(); tick();
    rsv_a = 5'd5; apply(); tick();
    rsv_v = 0; v[2] = 1; a[2] = 5'd9; d[2] = 32'h9999_0009; apply(); tick();
    v[2] = 0; v[1] = 1; a[1] = 5'd10; d[1] = 32'h1010_1010; apply(); #1;
    n_checks++; if (pending_mask !== 32'h0000_0021 || bus.rf_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: got pend=%h we=%b want 00000021/1", pending_mask,
        bus.rf_write_enable); end
  endtask

  task automatic test_flush();
    setup_staged();
    flush = 1; rsv_v = 1; rsv_a = 5'd3; apply(); #1;
    n_checks++; if (bus.req_ready !== '0 || bus.rsv_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_ready: got rdy=%b rsv=%b want 0000/0", bus.req_ready,
        bus.rsv_ready); end
    tick(); flush = 0; rsv_v = 0; apply(); #1;
    n_checks++; if (pending_mask !== '0 || bus.rf_write_enable !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: got pend=%h we=%b err=%b want 0/0/0",
        pending_mask, bus.rf_write_enable, err); end
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++;
      $display("FAIL flush_ptr_hold: got %b want 0010", bus.req_ready); end
    tick(); v[1] = 0; apply();

    setup_staged();
    rst = 1; model_reset(); #1;
    n_checks++; if (bus.req_ready !== '0 || pending_mask !== '0 ||
                    bus.rf_write_enable !== 1'b0 || err !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_async: got rdy=%b pend=%h we=%b err=%b want 0", bus.req_ready,
        pending_mask, bus.rf_write_enable, err); end
    @(negedge clk); rst = 0; #1;
    tick(); #1;
    n_checks++; if (err !== 1'b0 || pending_mask !== '0) begin n_fail++;
      $display("FAIL rstmid_after: got err=%b pend=%h want 0/0", err, pending_mask); end
    v = '0; apply(); tick();
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int s = $urandom_range(0, NUM_REGS - 1);
    if (m_pend != '0 && ($urandom % 4) != 0) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        int r = (s + k) % NUM_REGS;
        if (m_pend[r]) return ADDR_W'(r);
      end
    end
    return ADDR_W'(s);
  endfunction

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (v[i] && m_last == i) v[i] = 0;
        if (!v[i] && ($urandom % 3) == 0) begin
          v[i] = 1; a[i] = pick_addr(); d[i] = $urandom;
        end
      end
      rsv_v = $urandom_range(0, 1);
      rsv_a = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      flush = (($urandom % 20) == 0);
      apply(); #1;
      n_checks++; if (bus.req_ready !== exp_ready()) begin n_fail++;
        $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, exp_ready()); end
      n_checks++; if (bus.rsv_ready !== exp_rsv_ready()) begin n_fail++;
        $display("FAIL rnd_rsv c%0d: got %b want %b", c, bus.rsv_ready, exp_rsv_ready()); end
      n_checks++; if (bus.rf_write_enable !== m_we ||
                      (m_we && (bus.rf_write_addr !== m_waddr || bus.rf_write_data !== m_wdata)))
      begin n_fail++;
        $display("FAIL rnd_write c%0d: got we=%b a=%0d d=%h want %b/%0d/%h", c,
          bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, m_we, m_waddr, m_wdata);
      end
      n_checks++; if (pending_mask !== m_pend || err !== m_err) begin n_fail++;
        $display("FAIL rnd_sb c%0d: got pend=%h err=%b want %h/%b", c, pending_mask, err,
          m_pend, m_err); end
      tick();
    end
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_back_to_back();
    test_scoreboard();
    test_unreserved();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
